// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared defaults and alignment helpers for the pc generator
package pc_pkg;

    localparam logic [31:0] DEF_RESET_VEC  = 32'h0000_0000;
    localparam int          DEF_INST_BYTES = 4;
    localparam int          ALIGN_BITS     = $clog2(DEF_INST_BYTES);

    // Clears the low 'bits' bits of an address; callers truncate to their width.
    function automatic logic [63:0] align(input logic [63:0] x, input int unsigned bits);
        logic [63:0] w_mask;
        w_mask = ~64'h0 << bits;
        return x & w_mask;
    endfunction

    function automatic logic misaligned(input logic [63:0] x, input int unsigned bits);
        logic [63:0] w_mask;
        w_mask = ~(~64'h0 << bits);
        return (x & w_mask) != 64'h0;
    endfunction

endpackage

// File: rtl/pc_gen_if.sv
// rtl/pc_gen_if.sv - fetch front-end redirect/stall inputs and pc outputs
interface pc_gen_if #(
    parameter int ADDR_W  = 32,
    parameter int STALL_W = 6
) ();
    logic [STALL_W-1:0] pc_stall;
    logic               branch_flag_i;
    logic [ADDR_W-1:0]  branch_target_address_i;
    logic               flush_i;
    logic [ADDR_W-1:0]  flush_target_i;
    logic [ADDR_W-1:0]  pc;
    logic               ce;
    logic               branch_pending_o;
    logic               misalign_o;

    modport master (
        output pc_stall, branch_flag_i, branch_target_address_i, flush_i, flush_target_i,
        input  pc, ce, branch_pending_o, misalign_o
    );

    modport slave (
        input  pc_stall, branch_flag_i, branch_target_address_i, flush_i, flush_target_i,
        output pc, ce, branch_pending_o, misalign_o
    );
endinterface

// File: rtl/pc_next_sel.sv
// rtl/pc_next_sel.sv - next-pc priority mux: flush, stall, branch, pending, sequential
module pc_next_sel
    import pc_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int INST_BYTES = DEF_INST_BYTES
) (
    input  logic              i_ce,
    input  logic              i_flush,
    input  logic              i_stall,
    input  logic              i_branch,
    input  logic              i_pend_valid,
    input  logic [ADDR_W-1:0] i_pc,
    input  logic [ADDR_W-1:0] i_flush_target,
    input  logic [ADDR_W-1:0] i_branch_target,
    input  logic [ADDR_W-1:0] i_pend_addr,
    output logic [ADDR_W-1:0] o_next_pc,
    output logic              o_pend_valid,
    output logic [ADDR_W-1:0] o_pend_addr,
    output logic              o_misalign
);
    localparam int unsigned ALIGN_B = $clog2(INST_BYTES);

    logic [ADDR_W-1:0] w_flush_al;
    logic [ADDR_W-1:0] w_branch_al;
    logic              w_flush_mis;
    logic              w_branch_mis;

    assign w_flush_al   = ADDR_W'(align(64'(i_flush_target), ALIGN_B));
    assign w_branch_al  = ADDR_W'(align(64'(i_branch_target), ALIGN_B));
    assign w_flush_mis  = misaligned(64'(i_flush_target), ALIGN_B);
    assign w_branch_mis = misaligned(64'(i_branch_target), ALIGN_B);

    always_comb begin
        o_next_pc    = i_pc;
        o_pend_valid = i_pend_valid;
        o_pend_addr  = i_pend_addr;
        o_misalign   = 1'b0;
        if (i_ce) begin
            if (i_flush) begin
                o_next_pc    = w_flush_al;
                o_pend_valid = 1'b0;
                o_misalign   = w_flush_mis;
            end else if (i_stall) begin
                // A branch during a stall is parked; the newest one overwrites.
                if (i_branch) begin
                    o_pend_valid = 1'b1;
                    o_pend_addr  = w_branch_al;
                    o_misalign   = w_branch_mis;
                end
            end else if (i_branch) begin
                o_next_pc    = w_branch_al;
                o_pend_valid = 1'b0;
                o_misalign   = w_branch_mis;
            end else if (i_pend_valid) begin
                o_next_pc    = i_pend_addr;
                o_pend_valid = 1'b0;
            end else begin
                o_next_pc = i_pc + ADDR_W'(INST_BYTES);
            end
        end
    end

endmodule

// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - program counter register with chip enable and pending-branch buffer
module pc_gen
    import pc_pkg::*;
#(
    parameter int          ADDR_W     = 32,
    parameter logic [31:0] RESET_VEC  = DEF_RESET_VEC,
    parameter int          INST_BYTES = DEF_INST_BYTES,
    parameter int          STALL_W    = 6
) (
    input  logic      clk,
    input  logic      reset_n,
    pc_gen_if.slave   bus
);
    logic [ADDR_W-1:0] r_pc;
    logic              r_ce;
    logic              r_pend_valid;
    logic [ADDR_W-1:0] r_pend_addr;
    logic              r_misalign;

    logic [ADDR_W-1:0] w_next_pc;
    logic              w_pend_valid;
    logic [ADDR_W-1:0] w_pend_addr;
    logic              w_misalign;
    logic              w_unused_stall;

    // Only the PC-stage stall bit matters here.
    assign w_unused_stall = ^bus.pc_stall;

    pc_next_sel #(
        .ADDR_W     (ADDR_W),
        .INST_BYTES (INST_BYTES)
    ) u_next_sel (
        .i_ce            (r_ce),
        .i_flush         (bus.flush_i),
        .i_stall         (bus.pc_stall[0]),
        .i_branch        (bus.branch_flag_i),
        .i_pend_valid    (r_pend_valid),
        .i_pc            (r_pc),
        .i_flush_target  (bus.flush_target_i),
        .i_branch_target (bus.branch_target_address_i),
        .i_pend_addr     (r_pend_addr),
        .o_next_pc       (w_next_pc),
        .o_pend_valid    (w_pend_valid),
        .o_pend_addr     (w_pend_addr),
        .o_misalign      (w_misalign)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_pc         <= ADDR_W'(RESET_VEC);
            r_ce         <= 1'b0;
            r_pend_valid <= 1'b0;
            r_pend_addr  <= '0;
            r_misalign   <= 1'b0;
        end else begin
            r_ce         <= 1'b1;
            r_pc         <= w_next_pc;
            r_pend_valid <= w_pend_valid;
            r_pend_addr  <= w_pend_addr;
            r_misalign   <= w_misalign;
        end
    end

    assign bus.pc               = r_pc;
    assign bus.ce               = r_ce;
    assign bus.branch_pending_o = r_pend_valid;
    assign bus.misalign_o       = r_misalign;

endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised program-counter generator for the jump/branch fetch front end; successor to the fixed 32-bit PC register. Produces the fetch address and instruction-memory chip enable each cycle, with configurable address width, reset vector and instruction size. Adds a flush/exception redirect port, a one-entry pending-branch buffer so a branch raised during a fetch stall is applied rather than lost, and misaligned-target detection.

## Interface
- ADDR_W, 32: width of pc and all target addresses
- RESET_VEC, 32'h0000_0000: pc value during and after reset (ADDR_W bits used)
- INST_BYTES, 4: sequential increment; power of two, ≥1
- STALL_W, 6: width of pipeline stall vector; bit 0 is the PC stage
- clk  in  1  clock, all state on rising edge
- reset_n  in  1  reset, synchronous, active-low
- pc_stall  in  STALL_W  stall vector; only pc_stall[0] is used
- branch_flag_i  in  1  branch/jump taken this cycle
- branch_target_address_i  in  ADDR_W  branch/jump target
- flush_i  in  1  exception/flush redirect request
- flush_target_i  in  ADDR_W  redirect address (handler vector)
- pc  out  ADDR_W  current fetch address (registered)
- ce  out  1  instruction-memory enable (registered)
- branch_pending_o  out  1  buffered branch awaiting stall release
- misalign_o  out  1  one-cycle pulse: accepted target was misaligned

## Operation
- Reset (reset_n=0 at a rising edge): pc=RESET_VEC, ce=0, pending buffer empty, branch_pending_o=0, misalign_o=0. Applies mid-operation identically; pending branch discarded.
- ce: 0 during reset; 1 from the first edge with reset_n=1 onward.
- While ce=0: pc holds; branch_flag_i and flush_i ignored, nothing buffered.
- While ce=1, next-pc priority, highest first:
  - flush_i=1: pc<=align(flush_target_i), pending cleared. Overrides stall and branch.
  - pc_stall[0]=1: pc holds. If branch_flag_i=1, pending<=align(branch_target_address_i), valid set; a newer branch while pending overwrites (latest wins).
  - branch_flag_i=1: pc<=align(branch_target_address_i); any pending entry cleared (live branch supersedes).
  - pending valid: pc<=pending address, pending cleared.
  - otherwise: pc<=pc+INST_BYTES, modulo 2^ADDR_W (all-ones region wraps to 0, no flag).
- align(x): low log2(INST_BYTES) bits forced to 0. If a flush or branch target whose bits were non-zero is accepted (applied or buffered), misalign_o=1 the next cycle, otherwise 0. With INST_BYTES=1 misalign_o is constantly 0.
- branch_pending_o mirrors the buffer valid bit.

## Timing
- All outputs registered; zero combinational paths input->output.
- Redirect latency: branch/flush asserted in cycle N (not stalled) -> pc shows target in N+1.
- Stalled branch: captured at edge ending cycle N; branch_pending_o=1 from N+1; pc takes target on the edge ending the first cycle with pc_stall[0]=0, branch_pending_o drops same edge.
- Flush in the same cycle as a branch, stall or pending: flush wins; pending cleared at that edge.
- Stall released and new branch in the same cycle: new branch target used, pending dropped.
- First pc change after reset: earliest at the second edge with reset_n=1 (first edge only raises ce).

## Structure
- Shared package pc_pkg: RESET_VEC default, INST_BYTES default, localparam ALIGN_BITS=$clog2(INST_BYTES), align function.
- Sub-module pc_next_sel: combinational priority mux (flush / stall / branch / pending / sequential) returning next pc, next pending state and misalign flag; pc_gen keeps only registers and ce.

## Test plan
- Reset then run, ADDR_W=32, RESET_VEC=0x100, INST_BYTES=4, no stall -> ce=0 during reset, ce=1 next edge, pc 0x100,0x104,0x108 on subsequent edges.
- Stall held 3 cycles with branch_flag_i=1 to 0x2000 in stall cycle 1 -> pc frozen, branch_pending_o=1, first unstalled edge pc=0x2000, pending=0.
- Branch 0x3000 then 0x4000 both during stall -> after release pc=0x4000 (latest wins).
- flush_i=1 target 0x8000_0180 with stall=1, branch=1, pending valid -> next pc=0x8000_0180, branch_pending_o=0.
- Branch target 0x1006 -> pc=0x1004, misalign_o=1 for exactly one cycle; INST_BYTES=1 build -> pc=0x1006, misalign_o=0.
- ADDR_W=16, pc=0xFFFC, no events -> pc=0x0000; reset_n=0 asserted mid-stall with pending -> pc=RESET_VEC, ce=0, pending cleared.
